// File: rtl/bin_mul_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier: FSM states
// and the iteration-counter width helper.
package bin_mul_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // The counter only has to reach W-1, but W+1 keeps W=1-style corner cases sane.
  function automatic int bin_mul_cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/bin_mul_step.sv
// One shift-and-add iteration: conditionally add the multiplicand into acc,
// then shift the concatenation {acc, mq} right by one bit.
module bin_mul_step #(
  parameter int W = 4
) (
  input  logic [W:0]   acc_i,
  input  logic [W-1:0] mq_i,
  input  logic [W-1:0] mcand_i,
  output logic [W:0]   acc_o,
  output logic [W-1:0] mq_o
);

  logic [W:0] sum;

  always_comb begin
    sum   = acc_i + (mq_i[0] ? {1'b0, mcand_i} : '0);
    acc_o = {1'b0, sum[W:1]};
    mq_o  = {sum[0], mq_i[W-1:1]};
  end

endmodule

// File: rtl/bin_mul_seq.sv
// Sequential W-bit shift-and-add multiplier with start/busy/done handshake.
// Define BIN_MUL_SEQ_SIGNED_EN for two's-complement operands and product.
module bin_mul_seq
  import bin_mul_pkg::*;
#(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] z
);

  localparam int CNT_W = bin_mul_cnt_w(W);

  state_e state_q, state_d;

  logic [W-1:0]   mcand_q;
  logic [W-1:0]   mq_q, mq_d;
  logic [W:0]     acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2*W-1:0] z_q;
  logic           done_q;

  logic           accept;
  logic           lastIter;
  logic [W-1:0]   magX, magY;
  logic [2*W-1:0] prod, result;

  assign accept   = (state_q == IDLE) && start;
  assign lastIter = (state_q == RUN) && (cnt_q == CNT_W'(W - 1));
  assign prod     = {acc_d[W-1:0], mq_d};

  bin_mul_step #(.W(W)) u_step (
    .acc_i   (acc_q),
    .mq_i    (mq_q),
    .mcand_i (mcand_q),
    .acc_o   (acc_d),
    .mq_o    (mq_d)
  );

`ifdef BIN_MUL_SEQ_SIGNED_EN
  // Multiply magnitudes and fix the sign at the end; |-2^(W-1)| still fits in W bits.
  logic neg_q;

  assign magX   = x[W-1] ? -x : x;
  assign magY   = y[W-1] ? -y : y;
  assign result = neg_q ? -prod : prod;

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q <= 1'b0;
    end else if (accept) begin
      neg_q <= x[W-1] ^ y[W-1];
    end
  end
`else
  assign magX   = x;
  assign magY   = y;
  assign result = prod;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)    state_d = RUN;
      RUN:     if (lastIter) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = done_q;
    z    = z_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q <= '0;
      mq_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      z_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        mcand_q <= magX;
        mq_q    <= magY;
        acc_q   <= '0;
        cnt_q   <= '0;
      end else if (state_q == RUN) begin
        acc_q <= acc_d;
        mq_q  <= mq_d;
        cnt_q <= cnt_q + CNT_W'(1);
        if (lastIter) begin
          z_q    <= result;
          done_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bin_mul_seq.sv
// Directed self-checking bench for bin_mul_seq at W=2, 4 and 8; the signed
// vectors are exercised when BIN_MUL_SEQ_SIGNED_EN is defined.
module tb_bin_mul_seq;

  logic clk;
  logic rst;

  logic       s2, busy2, done2;
  logic [1:0] x2, y2;
  logic [3:0] z2;

  logic       s4, busy4, done4;
  logic [3:0] x4, y4;
  logic [7:0] z4;

  logic        s8, busy8, done8;
  logic [7:0]  x8, y8;
  logic [15:0] z8;

  int compared   = 0;
  int mismatched = 0;

  bin_mul_seq #(.W(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(s2), .x(x2), .y(y2),
    .busy(busy2), .done(done2), .z(z2)
  );

  bin_mul_seq #(.W(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(s4), .x(x4), .y(y4),
    .busy(busy4), .done(done4), .z(z4)
  );

  bin_mul_seq #(.W(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(s8), .x(x8), .y(y8),
    .busy(busy8), .done(done8), .z(z8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop so a wedged design can never hang the run.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  function automatic logic doneOf(input int dut);
    case (dut)
      2:       return done2;
      4:       return done4;
      default: return done8;
    endcase
  endfunction

  function automatic logic busyOf(input int dut);
    case (dut)
      2:       return busy2;
      4:       return busy4;
      default: return busy8;
    endcase
  endfunction

  function automatic logic [15:0] zOf(input int dut);
    case (dut)
      2:       return {12'h000, z2};
      4:       return {8'h00, z4};
      default: return z8;
    endcase
  endfunction

  // Present start for one accepting edge, then drop it.
  task automatic applyStimulus(input int dut, input logic [7:0] a, input logic [7:0] b);
    case (dut)
      2:       begin s2 = 1'b1; x2 = a[1:0]; y2 = b[1:0]; end
      4:       begin s4 = 1'b1; x4 = a[3:0]; y4 = b[3:0]; end
      default: begin s8 = 1'b1; x8 = a;      y8 = b;      end
    endcase
    stepClock();
    s2 = 1'b0;
    s4 = 1'b0;
    s8 = 1'b0;
  endtask

  task automatic runOp(input int dut, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] expZ, input int expLat, input string tag);
    int cyc;
    applyStimulus(dut, a, b);
    cyc = 0;
    while (!doneOf(dut) && cyc < 50) begin
      stepClock();
      cyc++;
    end
    checkOutput({tag, ".latency"}, cyc, expLat);
    checkOutput({tag, ".z"}, {16'h0000, zOf(dut)}, {16'h0000, expZ});
    checkOutput({tag, ".busy"}, {31'd0, busyOf(dut)}, 32'd0);
  endtask

  initial begin
    int bc;
    int doneCnt;
    int busyDoneClash;

    rst = 1'b1;
    s2 = 1'b0; x2 = '0; y2 = '0;
    s4 = 1'b0; x4 = '0; y4 = '0;
    s8 = 1'b0; x8 = '0; y8 = '0;
    stepClock();
    stepClock();

    checkOutput("reset.busy2", {31'd0, busy2}, 32'd0);
    checkOutput("reset.done2", {31'd0, done2}, 32'd0);
    checkOutput("reset.z2", {28'd0, z2}, 32'd0);
    checkOutput("reset.busy8", {31'd0, busy8}, 32'd0);
    checkOutput("reset.done8", {31'd0, done8}, 32'd0);
    checkOutput("reset.z8", {16'd0, z8}, 32'd0);

    // Start while reset is high must be ignored.
    s8 = 1'b1; x8 = 8'd3; y8 = 8'd3;
    stepClock();
    s8 = 1'b0;
    checkOutput("rst_vs_start.busy8", {31'd0, busy8}, 32'd0);
    rst = 1'b0;
    stepClock();

`ifndef BIN_MUL_SEQ_SIGNED_EN
    // W=2, issued back to back (start lands in each done cycle).
    runOp(2, 8'd2, 8'd1, 16'h0002, 2, "w2_10x01");
    runOp(2, 8'd3, 8'd3, 16'h0009, 2, "w2_11x11");
    runOp(2, 8'd0, 8'd0, 16'h0000, 2, "w2_00x00");
    runOp(2, 8'd3, 8'd2, 16'h0006, 2, "w2_11x10");
    runOp(2, 8'd2, 8'd3, 16'h0006, 2, "w2_10x11");

    runOp(4, 8'd15, 8'd15, 16'h00E1, 4, "w4_15x15");

    // W=8 max operands with busy-width and done-pulse checks.
    stepClock();
    applyStimulus(8, 8'd255, 8'd255);
    bc = 0;
    while (busy8 && bc < 50) begin
      bc++;
      stepClock();
    end
    checkOutput("w8_max.busy_cycles", bc, 8);
    checkOutput("w8_max.done", {31'd0, done8}, 32'd1);
    checkOutput("w8_max.z", {16'd0, z8}, 32'h0000FE01);
    stepClock();
    checkOutput("w8_max.done_pulse", {31'd0, done8}, 32'd0);

    // Start held high: accepts only every 9 cycles; x/y scrambled mid-run.
    doneCnt = 0;
    busyDoneClash = 0;
    s8 = 1'b1;
    for (int e = 0; e < 27; e++) begin
      if (e % 9 == 0) begin
        x8 = 8'd12;
        y8 = 8'd10;
      end else begin
        x8 = 8'($urandom_range(0, 255));
        y8 = 8'($urandom_range(0, 255));
      end
      stepClock();
      if (busy8 && done8) busyDoneClash++;
      if (done8) begin
        doneCnt++;
        checkOutput("w8_held.done_slot", e % 9, 8);
        checkOutput("w8_held.z", {16'd0, z8}, 32'd120);
      end
    end
    s8 = 1'b0;
    checkOutput("w8_held.done_count", doneCnt, 3);
    checkOutput("w8_held.busy_done_clash", busyDoneClash, 0);

    // Reset three cycles into a run aborts it and clears z.
    stepClock();
    applyStimulus(8, 8'd200, 8'd3);
    stepClock();
    stepClock();
    stepClock();
    rst = 1'b1;
    stepClock();
    rst = 1'b0;
    checkOutput("w8_abort.busy", {31'd0, busy8}, 32'd0);
    checkOutput("w8_abort.done", {31'd0, done8}, 32'd0);
    checkOutput("w8_abort.z", {16'd0, z8}, 32'd0);
    runOp(8, 8'd7, 8'd6, 16'd42, 8, "w8_after_abort");
`else
    runOp(4, 8'h0D, 8'h05, 16'h00F1, 4, "w4s_m3x5");
    runOp(4, 8'h08, 8'h08, 16'h0040, 4, "w4s_m8xm8");
    runOp(4, 8'h07, 8'h0F, 16'h00F9, 4, "w4s_7xm1");
    runOp(4, 8'h00, 8'h08, 16'h0000, 4, "w4s_0xm8");
    runOp(2, 8'h02, 8'h01, 16'h000E, 2, "w2s_m2x1");
    runOp(8, 8'hFF, 8'hFF, 16'h0001, 8, "w8s_m1xm1");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
